// File: rtl/interval_meter.sv
// Interval meter: counts 1 ms ticks between Start and Stop, saturating at 1023 ms.
// Optional BCD mirror of the count is built when INTERVAL_METER_BCD_EN is defined.
module interval_meter (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Clear,
    input  logic        MsTick,
    output logic [9:0]  Elapsed,
    output logic        Busy,
    output logic        Done,
    output logic        Overflow
`ifdef INTERVAL_METER_BCD_EN
    ,
    output logic [15:0] ElapsedBcd
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [9:0] MAX_COUNT = 10'd1023;

    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_elapsed;
    logic [9:0] w_elapsed_next;
    logic       r_ovf;
    logic       w_ovf_next;
    logic       r_busy;
    logic       r_done;
    logic       w_clr_cnt;
    logic       w_inc;
    logic       w_sat;

    // Clear outranks everything; within RUN a same-cycle tick is counted before Stop freezes.
    always_comb begin
        w_state_next = r_state;
        w_clr_cnt    = 1'b0;
        w_inc        = 1'b0;
        w_sat        = 1'b0;
        if (Clear) begin
            w_state_next = S_IDLE;
            w_clr_cnt    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        w_state_next = S_RUN;
                        w_clr_cnt    = 1'b1;
                    end
                end
                S_RUN: begin
                    if (MsTick) begin
                        if (r_elapsed == MAX_COUNT) begin
                            w_sat = 1'b1;
                        end else begin
                            w_inc = 1'b1;
                        end
                    end
                    if (Stop) begin
                        w_state_next = S_DONE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_clr_cnt    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_elapsed_next = r_elapsed;
        w_ovf_next     = r_ovf;
        if (w_clr_cnt) begin
            w_elapsed_next = 10'd0;
            w_ovf_next     = 1'b0;
        end else if (w_inc) begin
            w_elapsed_next = r_elapsed + 10'd1;
        end else if (w_sat) begin
            w_ovf_next = 1'b1;
        end
    end

    // Busy/Done are registered from the next state so they line up with the count.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state   <= S_IDLE;
            r_elapsed <= 10'd0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_elapsed <= w_elapsed_next;
            r_ovf     <= w_ovf_next;
            r_busy    <= (w_state_next == S_RUN);
            r_done    <= (w_state_next == S_DONE);
        end
    end

    assign Elapsed  = r_elapsed;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Overflow = r_ovf;

`ifdef INTERVAL_METER_BCD_EN
    logic [15:0] r_bcd;
    logic [15:0] w_bcd_inc;
    logic [3:0]  w_carry;

    assign w_carry[0] = 1'b1;

    // Ripple decimal carry digit by digit; saturation needs no logic since the
    // count simply stops incrementing at 1023.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] w_d;
            assign w_d = r_bcd[4*gi +: 4];
            assign w_bcd_inc[4*gi +: 4] = w_carry[gi] ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) : w_d;
            if (gi < 3) begin : g_carry
                assign w_carry[gi+1] = w_carry[gi] && (w_d == 4'd9);
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_bcd <= 16'h0000;
        end else if (w_clr_cnt) begin
            r_bcd <= 16'h0000;
        end else if (w_inc) begin
            r_bcd <= w_bcd_inc;
        end
    end

    assign ElapsedBcd = r_bcd;
`endif

endmodule

// File: tb/tb_interval_meter.sv
// Self-checking bench for interval_meter: directed scenarios plus a randomized run
// against a behavioural model. Define INTERVAL_METER_BCD_EN to cover the BCD output.
module tb_interval_meter;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic       Stop;
    logic       Clear;
    logic       MsTick;
    logic [9:0] Elapsed;
    logic       Busy;
    logic       Done;
    logic       Overflow;
`ifdef INTERVAL_METER_BCD_EN
    logic [15:0] ElapsedBcd;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the meter's observable state.
    int m_count = 0;
    bit m_busy  = 0;
    bit m_done  = 0;
    bit m_ovf   = 0;

    interval_meter dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Stop      (Stop),
        .Clear     (Clear),
        .MsTick    (MsTick),
        .Elapsed   (Elapsed),
        .Busy      (Busy),
        .Done      (Done),
        .Overflow  (Overflow)
`ifdef INTERVAL_METER_BCD_EN
        ,
        .ElapsedBcd(ElapsedBcd)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] bcd_of(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic apply(input bit rst_n, input bit st, input bit sp, input bit cl, input bit tk);
        Rst    = rst_n;
        Start  = st;
        Stop   = sp;
        Clear  = cl;
        MsTick = tk;
    endtask

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic step();
        if (!Rst) begin
            m_count = 0; m_busy = 0; m_done = 0; m_ovf = 0;
        end else if (Clear) begin
            m_count = 0; m_busy = 0; m_done = 0; m_ovf = 0;
        end else if (m_busy) begin
            if (MsTick) begin
                if (m_count >= 1023) m_ovf = 1;
                else m_count = m_count + 1;
            end
            if (Stop) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (Start) begin
            m_busy = 1; m_done = 0; m_count = 0; m_ovf = 0;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1, 0, 0, 0, 1);
            step();
        end
    endtask

    task automatic test_reset();
        apply(0, 1, 1, 1, 1);
        step();
        n_tests++;
        if ({Busy, Done, Overflow, Elapsed} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset: busy/done/ovf/elapsed=%b/%b/%b/%0d required 0/0/0/0", Busy, Done, Overflow, Elapsed);
        end
`ifdef INTERVAL_METER_BCD_EN
        n_tests++;
        if (ElapsedBcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_bcd: got %h required 0000", ElapsedBcd);
        end
`endif
        $display("[TB] test_reset done");
    endtask

    task automatic test_count_250();
        apply(1, 1, 0, 0, 1);
        step();
        n_tests++;
        if (Busy !== 1'b1 || Elapsed !== 10'd0) begin
            n_fail++;
            $display("FAIL start_250: busy=%b elapsed=%0d required busy=1 elapsed=0", Busy, Elapsed);
        end
        ticks(100);
        n_tests++;
        if (Busy !== 1'b1 || Elapsed !== 10'd100) begin
            n_fail++;
            $display("FAIL live_count: busy=%b elapsed=%0d required busy=1 elapsed=100", Busy, Elapsed);
        end
        ticks(150);
        apply(1, 0, 1, 0, 0);
        step();
        n_tests++;
        if ({Busy, Done, Overflow, Elapsed} !== {3'b010, 10'd250}) begin
            n_fail++;
            $display("FAIL count_250: busy/done/ovf/elapsed=%b/%b/%b/%0d required 0/1/0/250", Busy, Done, Overflow, Elapsed);
        end
`ifdef INTERVAL_METER_BCD_EN
        n_tests++;
        if (ElapsedBcd !== 16'h0250) begin
            n_fail++;
            $display("FAIL bcd_250: got %h required 0250", ElapsedBcd);
        end
`endif
        $display("[TB] test_count_250 done elapsed=%0d", Elapsed);
    endtask

    task automatic test_saturate();
        apply(1, 1, 0, 0, 0);
        step();
        ticks(1023);
        n_tests++;
        if (Elapsed !== 10'd1023 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL at_max: elapsed=%0d ovf=%b required 1023/0", Elapsed, Overflow);
        end
        ticks(77);
        apply(1, 0, 1, 0, 0);
        step();
        n_tests++;
        if ({Busy, Done, Overflow, Elapsed} !== {3'b011, 10'd1023}) begin
            n_fail++;
            $display("FAIL saturate: busy/done/ovf/elapsed=%b/%b/%b/%0d required 0/1/1/1023", Busy, Done, Overflow, Elapsed);
        end
`ifdef INTERVAL_METER_BCD_EN
        n_tests++;
        if (ElapsedBcd !== 16'h1023) begin
            n_fail++;
            $display("FAIL bcd_sat: got %h required 1023", ElapsedBcd);
        end
`endif
        $display("[TB] test_saturate done elapsed=%0d ovf=%b", Elapsed, Overflow);
    endtask

    task automatic test_stop_with_tick();
        apply(1, 1, 0, 0, 0);
        step();
        n_tests++;
        if (Overflow !== 1'b0 || Done !== 1'b0 || Elapsed !== 10'd0) begin
            n_fail++;
            $display("FAIL restart_from_done: ovf=%b done=%b elapsed=%0d required 0/0/0", Overflow, Done, Elapsed);
        end
        ticks(5);
        apply(1, 0, 1, 0, 1);
        step();
        n_tests++;
        if (Done !== 1'b1 || Elapsed !== 10'd6) begin
            n_fail++;
            $display("FAIL stop_tick: done=%b elapsed=%0d required 1/6", Done, Elapsed);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, 0, 1);
            step();
        end
        n_tests++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Elapsed !== 10'd6) begin
            n_fail++;
            $display("FAIL done_hold: done=%b busy=%b elapsed=%0d required 1/0/6", Done, Busy, Elapsed);
        end
        $display("[TB] test_stop_with_tick done elapsed=%0d", Elapsed);
    endtask

    task automatic test_start_stop_same();
        apply(1, 1, 0, 0, 0);
        step();
        ticks(40);
        apply(1, 1, 1, 0, 0);
        step();
        n_tests++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Elapsed !== 10'd40) begin
            n_fail++;
            $display("FAIL start_stop: done=%b busy=%b elapsed=%0d required 1/0/40", Done, Busy, Elapsed);
        end
        apply(1, 1, 0, 0, 0);
        step();
        n_tests++;
        if (Busy !== 1'b1 || Done !== 1'b0 || Elapsed !== 10'd0) begin
            n_fail++;
            $display("FAIL restart: busy=%b done=%b elapsed=%0d required 1/0/0", Busy, Done, Elapsed);
        end
        $display("[TB] test_start_stop_same done");
    endtask

    task automatic test_clear();
        apply(1, 1, 0, 0, 0);
        step();
        ticks(99);
`ifdef INTERVAL_METER_BCD_EN
        n_tests++;
        if (ElapsedBcd !== 16'h0099) begin
            n_fail++;
            $display("FAIL bcd_99: got %h required 0099", ElapsedBcd);
        end
        ticks(1);
        n_tests++;
        if (ElapsedBcd !== 16'h0100 || Elapsed !== 10'd100) begin
            n_fail++;
            $display("FAIL bcd_carry: got %h/%0d required 0100/100", ElapsedBcd, Elapsed);
        end
        apply(1, 1, 0, 0, 0);
        step();
        apply(1, 0, 0, 0, 0);
        step();
        ticks(99);
`endif
        apply(1, 1, 1, 1, 1);
        step();
        n_tests++;
        if ({Busy, Done, Overflow, Elapsed} !== 13'd0) begin
            n_fail++;
            $display("FAIL clear: busy/done/ovf/elapsed=%b/%b/%b/%0d required 0/0/0/0", Busy, Done, Overflow, Elapsed);
        end
        $display("[TB] test_clear done");
    endtask

    task automatic test_reset_during_run();
        apply(1, 1, 0, 0, 0);
        step();
        ticks(12);
        apply(0, 0, 0, 0, 1);
        step();
        n_tests++;
        if ({Busy, Done, Overflow, Elapsed} !== 13'd0) begin
            n_fail++;
            $display("FAIL rst_run: busy/done/ovf/elapsed=%b/%b/%b/%0d required 0/0/0/0", Busy, Done, Overflow, Elapsed);
        end
        apply(1, 0, 1, 0, 1);
        step();
        n_tests++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_after_rst: done=%b busy=%b required 0/0", Done, Busy);
        end
        apply(1, 1, 0, 0, 1);
        step();
        n_tests++;
        if (Busy !== 1'b1 || Elapsed !== 10'd0) begin
            n_fail++;
            $display("FAIL start_after_rst: busy=%b elapsed=%0d required 1/0", Busy, Elapsed);
        end
        $display("[TB] test_reset_during_run done");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 1) == 1));
            step();
            n_tests++;
            if ({Busy, Done, Overflow, Elapsed} !== {m_busy, m_done, m_ovf, 10'(m_count)}) begin
                n_fail++;
                errs++;
                $display("FAIL random_%0d: busy/done/ovf/elapsed=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         i, Busy, Done, Overflow, Elapsed, m_busy, m_done, m_ovf, m_count);
            end
`ifdef INTERVAL_METER_BCD_EN
            n_tests++;
            if (ElapsedBcd !== bcd_of(m_count)) begin
                n_fail++;
                errs++;
                $display("FAIL random_bcd_%0d: got %h required %h", i, ElapsedBcd, bcd_of(m_count));
            end
`endif
        end
        $display("[TB] test_random done errors=%0d", errs);
    endtask

    initial begin
        apply(0, 0, 0, 0, 0);
        test_reset();
        test_count_250();
        test_saturate();
        test_stop_with_tick();
        test_start_stop_same();
        test_clear();
        test_reset_during_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interval_meter.md
INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 Rst  input  1  reset; synchronous, active-low.
REQ-003 Start  input  1  begin measurement; level sampled each Clk edge.
REQ-004 Stop  input  1  end measurement; level sampled each Clk edge.
REQ-005 Clear  input  1  abandon or discard measurement, return to idle.
REQ-006 MsTick  input  1  one-cycle 1 ms time-base pulse from the 1 ms timer block.
REQ-007 Elapsed  output  10  measured interval in ms; unsigned, registered.
REQ-008 Busy  output  1  high while measuring; registered.
REQ-009 Done  output  1  high while a completed result is held; registered.
REQ-010 Overflow  output  1  high when the count saturated during the current or held measurement; registered.
REQ-011 ElapsedBcd  output  16  four BCD digits of Elapsed, thousands in [15:12]; present only with INTERVAL_METER_BCD_EN.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; Busy=1 only in RUN, Done=1 only in DONE.
REQ-013 Input priority, highest first: Rst, Clear, Stop, Start.
REQ-014 IDLE: Start=1 -> RUN after the same edge; Elapsed<=0, Overflow<=0; MsTick in that cycle not counted.
REQ-015 IDLE: Stop=1 without Start SHALL be ignored.
REQ-016 RUN: MsTick=1 with Elapsed<1023 -> Elapsed+1 on that edge.
REQ-017 RUN: MsTick=1 with Elapsed=1023 -> Elapsed holds 1023, Overflow<=1; no wrap to 0.
REQ-018 RUN: Stop=1 -> DONE after the same edge; an MsTick in the same cycle SHALL be counted (REQ-016/017 rules) before freezing.
REQ-019 RUN: Start=1 without Stop SHALL be ignored; measurement continues uninterrupted.
REQ-020 RUN and Stop=1 and Start=1 in one cycle -> Stop wins; enter DONE.
REQ-021 DONE: Elapsed and Overflow SHALL hold; MsTick and Stop are ignored.
REQ-022 DONE: Start=1 -> RUN with Elapsed<=0, Overflow<=0, as in REQ-014.
REQ-023 Any state: Clear=1 -> IDLE, Elapsed<=0, Overflow<=0, Busy<=0, Done<=0, regardless of Start/Stop/MsTick.
REQ-024 Latency: Busy, Done and Elapsed SHALL reflect an input sampled at edge k immediately after edge k; no further pipeline delay.
REQ-025 Elapsed SHALL track the live count during RUN, not only at completion.

Reset
REQ-026 Rst=0 at a Clk edge -> IDLE, Elapsed=0, Busy=0, Done=0, Overflow=0, ElapsedBcd=0x0000, regardless of other inputs.
REQ-027 Rst asserted during RUN SHALL discard the measurement; no Done pulse is produced.
REQ-028 After Rst returns high, the first edge with Start=1 SHALL begin a measurement per REQ-014.

Configuration
REQ-029 Macro INTERVAL_METER_BCD_EN defined: ElapsedBcd SHALL be a BCD counter updated on the same edges and under the same clear/increment/saturate rules as Elapsed, always equal to Elapsed in decimal; saturation value 0x1023.
REQ-030 BCD increment SHALL carry per digit with no binary-to-BCD conversion path; e.g. 0x0099 -> 0x0100 in one edge.
REQ-031 Macro undefined: ElapsedBcd port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, Start, 250 MsTick pulses, Stop -> Elapsed=250, Done=1, Busy=0, Overflow=0; with macro, ElapsedBcd=0x0250.
REQ-033 Start, 1100 MsTick pulses, Stop -> Elapsed=1023, Overflow=1, Done=1; with macro, ElapsedBcd=0x1023.
REQ-034 Start, 5 MsTick, Stop and MsTick in one cycle -> Elapsed=6; next 3 MsTick -> Elapsed stays 6.
REQ-035 RUN at Elapsed=40, Start+Stop in one cycle -> DONE, Elapsed=40; then Start -> Busy=1, Elapsed=0, Done=0.
REQ-036 RUN at Elapsed=99, Clear+Stop+MsTick in one cycle -> IDLE, Elapsed=0, Done=0, Busy=0.
REQ-037 RUN at Elapsed=12, Rst=0 for one edge -> all outputs 0; Stop afterwards -> ignored, Done stays 0.
